seq_divider: RTL and testbench

- Iterative 32-bit divider, radix-2 restoring, one quotient bit per clock.
- Responder side of the EX-stage divide handshake: EX holds `start_i` high and stalls while `ready_o` is low.
- When `ready_o` rises, EX writes `result_o` into HI/LO and drops `start_i`.
- Serves DIV and DIVU.

---
 rtl/seq_divider.sv | 149 ++++++++++++++
 tb/tb_seq_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider (DIV/DIVU), one quotient bit per clock.
// Holds its result in DONE until the requester drops start_i.
module seq_divider #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned RES_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                sgn_q, sgn_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_sub;
  logic                q_bit;
  logic [DATA_W:0]     rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // One restoring step plus the sign fix-up applied on the final step
  always_comb begin
    rem_shift = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_next  = q_bit ? rem_sub : rem_shift;
    quo_next  = {dvd_q[DATA_W-2:0], q_bit};
    quo_fix   = (sgn_q && (neg1_q ^ neg2_q)) ? (~quo_next + DATA_W'(1)) : quo_next;
    rem_fix   = (sgn_q && neg1_q) ? (~rem_next[DATA_W-1:0] + DATA_W'(1))
                                  : rem_next[DATA_W-1:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (start_i) begin
          sgn_d  = signed_div_i;
          neg1_d = opdata1_i[DATA_W-1];
          neg2_d = opdata2_i[DATA_W-1];
          if (opdata2_i == '0) begin
            result_d = {opdata1_i, {DATA_W{1'b1}}};
            ready_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            // Negating 0x8000_0000 yields itself, i.e. magnitude 2^31 unsigned
            dvd_d   = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + DATA_W'(1))
                                                            : opdata1_i;
            dvs_d   = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + DATA_W'(1))
                                                            : opdata2_i;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!start_i) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Flush wins over everything, including a completing step
    if (annul_i) begin
      state_d  = S_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table for results/latency plus
// hand-written abort, flush and reset sequences.
module tb_seq_divider;

  logic        clk;
  logic        resetn;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int errors;
  int checks;
  logic [63:0] last_exp;

  typedef struct {
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  seq_divider #(.DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start an op, scramble operands after the start edge, check latency,
  // result, hold-in-DONE and the release handshake.
  task automatic run_op(input vec_t v, input string name);
    int  n;
    bit  seen;
    @(negedge clk);
    signed_div = v.sgn;
    op1        = v.op1;
    op2        = v.op2;
    start      = 1'b1;
    n    = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready) seen = 1;
      if (n == 1) begin
        op1        = $urandom;
        op2        = $urandom;
        signed_div = ~signed_div;
      end
    end
    chk({name, " latency"}, 64'(n), 64'(v.lat));
    chk({name, " result"}, result, v.exp);
    repeat (2) @(posedge clk);
    #1;
    chk({name, " hold ready"}, 64'(ready), 64'd1);
    chk({name, " hold result"}, result, v.exp);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, " release ready"}, 64'(ready), 64'd0);
    chk({name, " release result"}, result, v.exp);
    last_exp = v.exp;
  endtask

  vec_t vecs[12];

  initial begin
    errors   = 0;
    checks   = 0;
    last_exp = '0;
    resetn     = 1'b0;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h0000_0002_0000_000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[2]  = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  64'h0000_0000_FFFF_FFFF, 33};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFF,  32'h0000_0001,  64'h0000_0000_FFFF_FFFF, 33};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 33};
    vecs[5]  = '{1'b0, 32'h0000_1234,  32'h0000_0000,  64'h0000_1234_FFFF_FFFF, 1};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  64'h0000_000F_0FFF_FFFF, 33};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 33};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFF_FFFE_0000_000E, 33};
    vecs[9]  = '{1'b0, 32'd5,          32'd10,         64'h0000_0005_0000_0000, 33};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h8000_0000_0000_0000, 33};
    vecs[11] = '{1'b1, 32'hFFFF_FFF0,  32'h0000_0000,  64'hFFFF_FFF0_FFFF_FFFF, 1};

    #12;
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Flush mid-operation at E10
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("annul busy ready", 64'(ready), 64'd0);
    chk("annul busy result", result, last_exp);
    @(negedge clk);
    annul = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("annul stays idle", 64'(ready), 64'd0);
    chk("annul result kept", result, last_exp);
    run_op('{1'b0, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 33}, "after annul");

    // Flush in DONE with start still high
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'h55; op2 = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    chk("div0 ready", 64'(ready), 64'd1);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    chk("annul done ready", 64'(ready), 64'd0);
    chk("annul done result", result, 64'h0000_0055_FFFF_FFFF);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;

    // Flush has priority over a start on the same edge
    @(negedge clk);
    op1 = 32'h77; op2 = 32'h0; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    chk("annul prio ready", 64'(ready), 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
    chk("annul prio no start", 64'(ready), 64'd0);
    chk("annul prio result", result, 64'h0000_0055_FFFF_FFFF);

    // Async reset at E15
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async rst ready", 64'(ready), 64'd0);
    chk("async rst result", result, 64'd0);
    @(negedge clk);
    start = 1'b0; resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post rst ready", 64'(ready), 64'd0);
    chk("post rst result", result, 64'd0);
    run_op(vecs[1], "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
